keypad_scanner: RTL and testbench

Parametrised matrix-keypad scanner with per-key debounce and a buffered key-event queue. Drives one active-low column at a time, samples the active-low row lines and debounces every key over consecutive scans. Each debounced press (and optionally release) is pushed into a FIFO that a consumer drains with a valid/ready handshake. It replaces the fixed 4x4 scan-and-button front end ahead of the calculator datapath.

---
 rtl/keypad_pkg.sv | 22 ++
 rtl/key_fifo.sv | 60 ++++++
 rtl/keypad_scanner.sv | 190 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
package keypad_pkg;

   localparam int KEY_CODE_MAX_W = 16;

   typedef enum logic [1:0] {
      ST_SETTLE,
      ST_SAMPLE,
      ST_EVAL,
      ST_ADVANCE
   } scan_state_e;

   typedef struct packed {
      logic                      rel;
      logic [KEY_CODE_MAX_W-1:0] code;
   } key_evt_t;

   function automatic int key_code_width(input int rows, input int cols);
      return (rows * cols > 1) ? $clog2(rows * cols) : 1;
   endfunction

endpackage

// File: rtl/key_fifo.sv
// Synchronous FIFO for key events; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module key_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign rdata_o = mem_q[rd_q];

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= wdata_i;
   end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner with per-key debounce and a buffered event queue.
// Define KEYPAD_RELEASE_EVT_EN to also queue key-release events.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int ROWS           = 4,
   parameter int COLS           = 4,
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int FIFO_DEPTH     = 4,
   localparam int CW            = key_code_width(ROWS, COLS)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [ROWS-1:0] key_in,
   output logic [COLS-1:0] key_out,
   output logic            key_valid,
   input  logic            key_ready,
   output logic [CW-1:0]   key_code,
   output logic            key_release,
   output logic            overflow,
   output logic            any_pressed
);

   localparam int NKEYS = ROWS * COLS;
   localparam int SLOTW = $clog2(SCAN_DIV);
   localparam int COLW  = $clog2(COLS);
   localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int DBW   = $clog2(DEBOUNCE_SCANS + 1);
`ifdef KEYPAD_RELEASE_EVT_EN
   localparam int EW    = CW + 1;
`else
   localparam int EW    = CW;
`endif

   // state      | meaning
   // SETTLE     | column col driven low, waiting SCAN_DIV cycles
   // SAMPLE     | latch inverted row lines
   // EVAL       | debounce one key (r, col) per cycle
   // ADVANCE    | step to next column
   scan_state_e state_q, state_d;

   logic [SLOTW-1:0] slot_q, slot_d;
   logic [COLW-1:0]  col_q, col_d;
   logic [RW-1:0]    r_q, r_d;
   logic [ROWS-1:0]  row_q, row_d;
   logic [NKEYS-1:0] stable_q, stable_d;
   logic [DBW-1:0]   cnt_q [NKEYS];
   logic [DBW-1:0]   cnt_d [NKEYS];
   logic             any_pressed_q, overflow_q;

   logic settle_en, sample_en, eval_en, adv_en;
   logic settle_done, last_row, last_col;
   logic [CW-1:0] code_cur;
   logic smp, flip, push_req, pop;
   logic fifo_full, fifo_empty;
   logic [EW-1:0] push_data, head_data;
   key_evt_t evt;
   logic unused_evt;

   assign settle_done = (slot_q == SLOTW'(SCAN_DIV - 1));
   assign last_row    = (r_q == RW'(ROWS - 1));
   assign last_col    = (col_q == COLW'(COLS - 1));
   assign code_cur    = CW'(int'(r_q) * COLS + int'(col_q));
   assign smp         = row_q[r_q];

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_SETTLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_SETTLE:  if (settle_done) state_d = ST_SAMPLE;
         ST_SAMPLE:  state_d = ST_EVAL;
         ST_EVAL:    if (last_row) state_d = ST_ADVANCE;
         ST_ADVANCE: state_d = ST_SETTLE;
         default:    state_d = ST_SETTLE;
      endcase
   end

   always_comb begin
      settle_en = 1'b0;
      sample_en = 1'b0;
      eval_en   = 1'b0;
      adv_en    = 1'b0;
      case (state_q)
         ST_SETTLE:  settle_en = 1'b1;
         ST_SAMPLE:  sample_en = 1'b1;
         ST_EVAL:    eval_en   = 1'b1;
         ST_ADVANCE: adv_en    = 1'b1;
         default:    settle_en = 1'b0;
      endcase
   end

   always_comb begin
      slot_d = '0;
      col_d  = col_q;
      r_d    = r_q;
      row_d  = row_q;
      if (settle_en && !settle_done) slot_d = slot_q + 1'b1;
      if (sample_en) begin
         row_d = ~key_in;
         r_d   = '0;
      end
      if (eval_en) r_d = last_row ? '0 : r_q + 1'b1;
      if (adv_en)  col_d = last_col ? '0 : col_q + 1'b1;
   end

   // A key flips only after DEBOUNCE_SCANS consecutive disagreeing scans.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      flip     = 1'b0;
      if (eval_en) begin
         if (smp == stable_q[code_cur]) begin
            cnt_d[code_cur] = '0;
         end else if (cnt_q[code_cur] == DBW'(DEBOUNCE_SCANS - 1)) begin
            stable_d[code_cur] = smp;
            cnt_d[code_cur]    = '0;
            flip               = 1'b1;
         end else begin
            cnt_d[code_cur] = cnt_q[code_cur] + 1'b1;
         end
      end
   end

   always_comb begin
      evt      = '0;
      evt.rel  = ~smp;
      evt.code = KEY_CODE_MAX_W'(code_cur);
   end

   assign unused_evt = ^evt;

`ifdef KEYPAD_RELEASE_EVT_EN
   assign push_req    = flip;
   assign push_data   = {evt.rel, evt.code[CW-1:0]};
   assign key_release = fifo_empty ? 1'b0 : head_data[CW];
`else
   assign push_req    = flip & smp;
   assign push_data   = evt.code[CW-1:0];
   assign key_release = 1'b0;
`endif

   assign key_valid   = ~fifo_empty;
   assign pop         = key_valid & key_ready;
   assign key_code    = fifo_empty ? '0 : head_data[CW-1:0];
   assign key_out     = ~(COLS'(1) << col_q);
   assign overflow    = overflow_q;
   assign any_pressed = any_pressed_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         slot_q        <= '0;
         col_q         <= '0;
         r_q           <= '0;
         row_q         <= '0;
         stable_q      <= '0;
         any_pressed_q <= 1'b0;
         overflow_q    <= 1'b0;
         for (int i = 0; i < NKEYS; i++) cnt_q[i] <= '0;
      end else begin
         slot_q        <= slot_d;
         col_q         <= col_d;
         r_q           <= r_d;
         row_q         <= row_d;
         stable_q      <= stable_d;
         any_pressed_q <= |stable_d;
         for (int i = 0; i < NKEYS; i++) cnt_q[i] <= cnt_d[i];
         if (push_req && fifo_full && !pop) overflow_q <= 1'b1;
      end
   end

   key_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .reset_i (reset),
      .push_i  (push_req),
      .pop_i   (pop),
      .wdata_i (push_data),
      .rdata_o (head_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a frame-level keypad model predicts events.
module tb_keypad_scanner;

   localparam int ROWS  = 4;
   localparam int COLS  = 4;
   localparam int SDIV  = 8;
   localparam int DEB   = 3;
   localparam int DEPTH = 4;
   localparam int NK    = ROWS * COLS;
   localparam int FRAME = COLS * (SDIV + ROWS + 2);
`ifdef KEYPAD_RELEASE_EVT_EN
   localparam bit REL_EN = 1'b1;
`else
   localparam bit REL_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            key_ready = 1'b0;
   logic [ROWS-1:0] key_in;
   logic [COLS-1:0] key_out;
   logic            key_valid;
   logic [3:0]      key_code;
   logic            key_release;
   logic            overflow;
   logic            any_pressed;
   logic [NK-1:0]   closed = '0;

   typedef struct {
      int code;
      bit rel;
   } ev_t;

   ev_t sb[$];
   bit  m_stable [NK];
   int  m_cnt    [NK];
   bit  exp_ovf;
   int  n_cmp = 0;
   int  n_bad = 0;
   int  n_pop = 0;

   always #5 clk = ~clk;

   keypad_scanner #(
      .ROWS           (ROWS),
      .COLS           (COLS),
      .SCAN_DIV       (SDIV),
      .DEBOUNCE_SCANS (DEB),
      .FIFO_DEPTH     (DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .key_in      (key_in),
      .key_out     (key_out),
      .key_valid   (key_valid),
      .key_ready   (key_ready),
      .key_code    (key_code),
      .key_release (key_release),
      .overflow    (overflow),
      .any_pressed (any_pressed)
   );

   // Physical matrix: a closed contact pulls its row low while its column is driven.
   always_comb begin
      key_in = '1;
      for (int c = 0; c < COLS; c++)
         if (key_out[c] == 1'b0)
            for (int r = 0; r < ROWS; r++)
               if (closed[r*COLS + c]) key_in[r] = 1'b0;
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int m_any();
      int a = 0;
      for (int k = 0; k < NK; k++) if (m_stable[k]) a = 1;
      return a;
   endfunction

   task automatic model_reset();
      sb.delete();
      exp_ovf = 1'b0;
      for (int k = 0; k < NK; k++) begin
         m_stable[k] = 1'b0;
         m_cnt[k]    = 0;
      end
   endtask

   task automatic expect_event(input int code, input bit rel);
      ev_t e;
      if (!key_ready && sb.size() >= DEPTH) begin
         exp_ovf = 1'b1;
      end else begin
         e.code = code;
         e.rel  = rel;
         sb.push_back(e);
      end
   endtask

   // One scan of every key, column-major, against the contacts held this frame.
   task automatic model_frame();
      for (int c = 0; c < COLS; c++)
         for (int r = 0; r < ROWS; r++) begin
            int k = r*COLS + c;
            if (closed[k] != m_stable[k]) begin
               m_cnt[k]++;
               if (m_cnt[k] == DEB) begin
                  m_stable[k] = closed[k];
                  m_cnt[k]    = 0;
                  if (closed[k] || REL_EN) expect_event(k, !closed[k]);
               end
            end else begin
               m_cnt[k] = 0;
            end
         end
   endtask

   task automatic frame_checks();
      check("any_pressed", any_pressed, m_any());
      check("overflow", overflow, exp_ovf);
      check("key_valid_frame_end", key_valid, (sb.size() != 0) ? 1 : 0);
   endtask

   task automatic run_frames(input int n);
      for (int i = 0; i < n; i++) begin
         model_frame();
         repeat (FRAME) @(posedge clk);
         #1;
         frame_checks();
      end
   endtask

   // Monitor: compare the head against the oldest expected event while it is shown.
   always @(negedge clk) begin
      if (!reset && key_valid) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: got code %0d rel %0b expected none (t=%0t)",
                     key_code, key_release, $time);
         end else begin
            check("head_code", key_code, sb[0].code);
            check("head_release", key_release, sb[0].rel);
            if (key_ready) begin
               void'(sb.pop_front());
               n_pop++;
            end
         end
      end
   end

   initial begin
      int p0;
      int seq [5] = '{0, 5, 10, 15, 3};

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_key_out", key_out, 4'b1110);
      check("rst_key_valid", key_valid, 0);
      check("rst_key_code", key_code, 0);
      check("rst_key_release", key_release, 0);
      check("rst_overflow", overflow, 0);
      check("rst_any_pressed", any_pressed, 0);

      model_frame();
      repeat (14) @(posedge clk);
      #1;
      check("col1_key_out", key_out, 4'b1101);
      repeat (FRAME - 14) @(posedge clk);
      #1;
      check("col_wrap_key_out", key_out, 4'b1110);
      frame_checks();

      // bounce: closed for fewer frames than the debounce depth
      key_ready = 1'b1;
      closed[9] = 1'b1;
      run_frames(2);
      closed[9] = 1'b0;
      p0 = n_pop;
      run_frames(3);
      check("bounce_events", n_pop - p0, 0);

      // clean press
      closed[9] = 1'b1;
      p0 = n_pop;
      run_frames(5);
      check("press_events", n_pop - p0, 1);

      // release
      closed[9] = 1'b0;
      p0 = n_pop;
      run_frames(4);
      check("release_events", n_pop - p0, REL_EN ? 1 : 0);

      // overflow with consumer stalled
      key_ready = 1'b0;
      foreach (seq[i]) begin
         closed[seq[i]] = 1'b1;
         run_frames(4);
      end
      check("overflow_sticky", overflow, 1);
      key_ready = 1'b1;
      p0 = n_pop;
      run_frames(1);
      check("overflow_drain_pops", n_pop - p0, 4);
      closed = '0;
      run_frames(4);

      // reset in the middle of EVAL with two events queued
      key_ready = 1'b0;
      closed[0] = 1'b1;
      closed[9] = 1'b1;
      run_frames(4);
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      model_reset();
      closed = '0;
      closed[9] = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_key_valid", key_valid, 0);
      check("midrst_key_out", key_out, 4'b1110);
      check("midrst_overflow", overflow, 0);
      check("midrst_any_pressed", any_pressed, 0);
      reset = 1'b0;
      key_ready = 1'b1;
      p0 = n_pop;
      run_frames(5);
      check("midrst_rereport", n_pop - p0, 1);

      // randomized contacts and consumer stalls
      for (int f = 0; f < 40; f++) begin
         key_ready = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < NK; k++)
            if ($urandom_range(0, 7) == 0) closed[k] = ~closed[k];
         run_frames(1);
      end
      key_ready = 1'b1;
      closed = '0;
      run_frames(5);
      check("scoreboard_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
